// File: rtl/maxpool_relu_2_if.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_relu_2_if
// Description : Pixel-stream bundle for the 2x2 max-pool + ReLU block.
//               The master drives three convolution channels plus a valid
//               strobe. The slave returns the pooled results and their strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface maxpool_relu_2_if #(
    parameter int CONV_BIT = 12
);
    logic                       valid_in;
    logic signed [CONV_BIT-1:0] conv_out_1;
    logic signed [CONV_BIT-1:0] conv_out_2;
    logic signed [CONV_BIT-1:0] conv_out_3;
    logic signed [CONV_BIT-1:0] max_value_1;
    logic signed [CONV_BIT-1:0] max_value_2;
    logic signed [CONV_BIT-1:0] max_value_3;
    logic                       valid_out_relu;

    modport master (
        output valid_in, conv_out_1, conv_out_2, conv_out_3,
        input  max_value_1, max_value_2, max_value_3, valid_out_relu
    );

    modport slave (
        input  valid_in, conv_out_1, conv_out_2, conv_out_3,
        output max_value_1, max_value_2, max_value_3, valid_out_relu
    );
endinterface
`default_nettype wire

// File: rtl/maxpool_relu_2.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_relu_2
// Description : Streaming 2x2/stride-2 max-pool followed by ReLU on three
//               signed channels. Even rows are pre-reduced pairwise into a
//               half-width line buffer. Odd rows finish each window and emit
//               one registered result per window.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_relu_2 #(
    parameter int CONV_BIT  = 12,
    parameter int IN_WIDTH  = 8,
    parameter int IN_HEIGHT = 8
) (
    input  logic             clk,
    input  logic             rst,
    maxpool_relu_2_if.slave  bus
);

    localparam int c_HALF  = IN_WIDTH / 2;
    localparam int c_COL_W = (IN_WIDTH  > 2) ? $clog2(IN_WIDTH)  : 1;
    localparam int c_ROW_W = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
    localparam int c_IDX_W = (c_HALF    > 1) ? $clog2(c_HALF)    : 1;
    localparam int c_NCH   = 3;

    typedef enum logic [0:0] {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_state_t;

    row_state_t                 r_state;
    logic [c_COL_W-1:0]         r_col;
    logic [c_ROW_W-1:0]         r_row;
    logic                       r_valid;
    logic signed [CONV_BIT-1:0] r_hold [c_NCH];
    logic signed [CONV_BIT-1:0] r_line [c_NCH][c_HALF];
    logic signed [CONV_BIT-1:0] r_max  [c_NCH];

    logic signed [CONV_BIT-1:0] w_pix  [c_NCH];
    logic signed [CONV_BIT-1:0] w_pair [c_NCH];
    logic signed [CONV_BIT-1:0] w_quad [c_NCH];
    logic signed [CONV_BIT-1:0] w_relu [c_NCH];
    logic [c_IDX_W-1:0]         w_idx;

    assign w_pix[0] = bus.conv_out_1;
    assign w_pix[1] = bus.conv_out_2;
    assign w_pix[2] = bus.conv_out_3;

    // A horizontal pixel pair shares one line-buffer slot.
    assign w_idx = c_IDX_W'(r_col >> 1);

    // Per-channel pair max, window max and ReLU clamp (all signed compares).
    for (genvar g = 0; g < c_NCH; g++) begin : g_ch
        assign w_pair[g] = (r_hold[g] > w_pix[g]) ? r_hold[g] : w_pix[g];
        assign w_quad[g] = (r_line[g][w_idx] > w_pair[g]) ? r_line[g][w_idx] : w_pair[g];
        assign w_relu[g] = w_quad[g][CONV_BIT-1] ? '0 : w_quad[g];
    end

    // Raster counters, row-phase FSM, pair/line storage and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ROW_EVEN;
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            for (int ch = 0; ch < c_NCH; ch++) begin
                r_hold[ch] <= '0;
                r_max[ch]  <= '0;
                for (int e = 0; e < c_HALF; e++) begin
                    r_line[ch][e] <= '0;
                end
            end
        end else begin
            r_valid <= 1'b0;
            if (bus.valid_in) begin
                if (r_col == c_COL_W'(IN_WIDTH - 1)) begin
                    r_col   <= '0;
                    r_state <= (r_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                    if (r_row == c_ROW_W'(IN_HEIGHT - 1)) begin
                        r_row <= '0;
                    end else begin
                        r_row <= r_row + c_ROW_W'(1);
                    end
                end else begin
                    r_col <= r_col + c_COL_W'(1);
                end

                if (!r_col[0]) begin
                    for (int ch = 0; ch < c_NCH; ch++) begin
                        r_hold[ch] <= w_pix[ch];
                    end
                end else if (r_state == ROW_EVEN) begin
                    for (int ch = 0; ch < c_NCH; ch++) begin
                        r_line[ch][w_idx] <= w_pair[ch];
                    end
                end else begin
                    for (int ch = 0; ch < c_NCH; ch++) begin
                        r_max[ch] <= w_relu[ch];
                    end
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.max_value_1    = r_max[0];
    assign bus.max_value_2    = r_max[1];
    assign bus.max_value_3    = r_max[2];
    assign bus.valid_out_relu = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_relu_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpool_relu_2
// Description : Self-checking bench for maxpool_relu_2 using directed ramp
//               frames, a table of single-window vectors and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_relu_2;

    localparam int CB = 12;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxpool_relu_2_if #(.CONV_BIT(CB)) bus();

    maxpool_relu_2 #(.CONV_BIT(CB), .IN_WIDTH(W), .IN_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [0:3][CB-1:0] w1;   // top-left, top-right, bottom-left, bottom-right
        logic [0:3][CB-1:0] w2;
        logic [0:3][CB-1:0] w3;
        logic [CB-1:0]      e1;
        logic [CB-1:0]      e2;
        logic [CB-1:0]      e3;
    } vec_t;

    vec_t          vecs [4];
    logic [CB-1:0] fr [3][N];
    int            cyc = 0;
    int            n_pass = 0;
    int            n_total = 0;
    int            exp_cyc_q[$];
    int            act_cyc_q[$];
    logic [CB-1:0] e1_q[$], e2_q[$], e3_q[$];
    logic [CB-1:0] a1_q[$], a2_q[$], a3_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output pulse shortly after the active edge.
    always @(posedge clk) begin
        #1;
        if (bus.valid_out_relu === 1'b1) begin
            act_cyc_q.push_back(cyc);
            a1_q.push_back(bus.max_value_1);
            a2_q.push_back(bus.max_value_2);
            a3_q.push_back(bus.max_value_3);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [CB-1:0] d1, d2, d3);
        @(negedge clk);
        rst            = 1'b0;
        bus.valid_in   = v;
        bus.conv_out_1 = d1;
        bus.conv_out_2 = d2;
        bus.conv_out_3 = d3;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, CB'($urandom), CB'($urandom), CB'($urandom));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        @(negedge clk);
    endtask

    // Stream the first npix pixels of fr; record when each window must appear.
    task automatic drive_frame(input int npix, input int gap_max);
        for (int i = 0; i < npix; i++) begin
            int gaps;
            gaps = (gap_max > 0 && i > 0) ? int'($urandom_range(0, gap_max)) : 0;
            idle(gaps);
            drive(1'b1, fr[0][i], fr[1][i], fr[2][i]);
            if (((i / W) % 2 == 1) && ((i % W) % 2 == 1)) exp_cyc_q.push_back(cyc + 1);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) begin
            fr[0][i] = CB'(i);
            fr[1][i] = 12'hFFB;
            fr[2][i] = CB'(63 - i);
        end
    endtask

    // Ramp windows: ch1 max is bottom-right index, ch3 max is 63 minus top-left.
    task automatic push_ramp_exp(input int npix);
        for (int pr = 0; pr < H / 2; pr++) begin
            for (int pc = 0; pc < W / 2; pc++) begin
                int idx;
                idx = (2 * pr + 1) * W + 2 * pc + 1;
                if (idx < npix) begin
                    e1_q.push_back(CB'(idx));
                    e2_q.push_back('0);
                    e3_q.push_back(CB'(63 - (2 * pr * W + 2 * pc)));
                end
            end
        end
    endtask

    task automatic compare(input string name);
        int n;
        chk({name, " count"}, act_cyc_q.size(), exp_cyc_q.size());
        n = (act_cyc_q.size() < exp_cyc_q.size()) ? act_cyc_q.size() : exp_cyc_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d] cycle", name, i), act_cyc_q[i], exp_cyc_q[i]);
            chk($sformatf("%s[%0d] ch1", name, i), int'(a1_q[i]), int'(e1_q[i]));
            chk($sformatf("%s[%0d] ch2", name, i), int'(a2_q[i]), int'(e2_q[i]));
            chk($sformatf("%s[%0d] ch3", name, i), int'(a3_q[i]), int'(e3_q[i]));
        end
        exp_cyc_q.delete(); act_cyc_q.delete();
        e1_q.delete(); e2_q.delete(); e3_q.delete();
        a1_q.delete(); a2_q.delete(); a3_q.delete();
    endtask

    initial begin
        int bad;
        vecs[0] = '{w1: {12'h800, 12'hFFF, 12'h003, 12'h002},
                    w2: {12'hFFF, 12'hFFE, 12'hFFD, 12'hFFC},
                    w3: {12'h005, 12'h007, 12'h064, 12'hFFF},
                    e1: 12'h003, e2: 12'h000, e3: 12'h064};
        vecs[1] = '{w1: {12'h800, 12'hFFF, 12'hFFE, 12'h801},
                    w2: {12'h7FF, 12'h000, 12'h000, 12'h000},
                    w3: {12'h001, 12'h002, 12'h003, 12'h004},
                    e1: 12'h000, e2: 12'h7FF, e3: 12'h004};
        vecs[2] = '{w1: {12'h7FE, 12'h7FF, 12'h800, 12'h000},
                    w2: {12'hFFF, 12'h005, 12'hFFF, 12'hFFF},
                    w3: {12'h000, 12'h000, 12'h000, 12'h000},
                    e1: 12'h7FF, e2: 12'h005, e3: 12'h000};
        vecs[3] = '{w1: {12'hFFD, 12'h006, 12'h002, 12'h001},
                    w2: {12'h008, 12'hFF8, 12'h009, 12'hFF7},
                    w3: {12'h801, 12'h7F0, 12'h800, 12'h7F1},
                    e1: 12'h006, e2: 12'h009, e3: 12'h7F1};

        bus.valid_in   = 1'b0;
        bus.conv_out_1 = '0;
        bus.conv_out_2 = '0;
        bus.conv_out_3 = '0;

        // Held in reset with toggling valid and random data.
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            bus.valid_in   = 1'($urandom);
            bus.conv_out_1 = CB'($urandom);
            bus.conv_out_2 = CB'($urandom);
            bus.conv_out_3 = CB'($urandom);
            @(posedge clk);
            #1;
            if (bus.valid_out_relu !== 1'b0 || bus.max_value_1 !== '0 ||
                bus.max_value_2 !== '0 || bus.max_value_3 !== '0) bad++;
        end
        chk("reset outputs nonzero cycles", bad, 0);
        chk("reset pulses", act_cyc_q.size(), 0);
        chk("reset max1", int'(bus.max_value_1), 0);
        chk("reset valid", int'(bus.valid_out_relu), 0);
        act_cyc_q.delete(); a1_q.delete(); a2_q.delete(); a3_q.delete();

        // Two back-to-back ramp frames; first pixel lands on first edge after release.
        load_ramp();
        push_ramp_exp(N);
        push_ramp_exp(N);
        drive_frame(N, 0);
        drive_frame(N, 0);
        idle(3);
        compare("b2b");
        chk("hold max1", int'(bus.max_value_1), 63);
        chk("hold max3", int'(bus.max_value_3), 9);

        // Asynchronous reset clears outputs without a clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async max1", int'(bus.max_value_1), 0);
        chk("async max3", int'(bus.max_value_3), 0);

        // Ramp frame with random idle gaps.
        push_ramp_exp(N);
        drive_frame(N, 3);
        idle(3);
        compare("gaps");

        // Abort after 20 pixels, then a clean frame.
        reset_dut();
        push_ramp_exp(20);
        drive_frame(20, 0);
        reset_dut();
        compare("abort_part");
        push_ramp_exp(N);
        drive_frame(N, 0);
        idle(3);
        compare("after_abort");

        // Single-window table: window 0 carries the vector, everything else is negative.
        for (int v = 0; v < 4; v++) begin
            reset_dut();
            for (int ch = 0; ch < 3; ch++)
                for (int i = 0; i < N; i++) fr[ch][i] = 12'hF9C;
            fr[0][0] = vecs[v].w1[0]; fr[0][1] = vecs[v].w1[1];
            fr[0][W] = vecs[v].w1[2]; fr[0][W+1] = vecs[v].w1[3];
            fr[1][0] = vecs[v].w2[0]; fr[1][1] = vecs[v].w2[1];
            fr[1][W] = vecs[v].w2[2]; fr[1][W+1] = vecs[v].w2[3];
            fr[2][0] = vecs[v].w3[0]; fr[2][1] = vecs[v].w3[1];
            fr[2][W] = vecs[v].w3[2]; fr[2][W+1] = vecs[v].w3[3];
            for (int w = 0; w < (W / 2) * (H / 2); w++) begin
                e1_q.push_back(w == 0 ? vecs[v].e1 : '0);
                e2_q.push_back(w == 0 ? vecs[v].e2 : '0);
                e3_q.push_back(w == 0 ? vecs[v].e3 : '0);
            end
            drive_frame(N, 0);
            idle(3);
            compare($sformatf("vec%0d", v));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maxpool_relu_2.md
MAXPOOL_RELU_2 -- requirements
Module: maxpool_relu_2

Interface
REQ-001 The block SHALL have parameter CONV_BIT, default 12, giving the signed pixel width.
REQ-002 The block SHALL have parameter IN_WIDTH, default 8, giving the input row length in pixels (even).
REQ-003 The block SHALL have parameter IN_HEIGHT, default 8, giving the input rows per frame (even).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1 bit: the asynchronous active-high reset.
REQ-007 The block SHALL have port valid_in, input, 1 bit: one pixel per channel is presented this cycle.
REQ-008 The block SHALL have ports conv_out_1, conv_out_2 and conv_out_3, input, CONV_BIT each: signed two's-complement convolution results, raster order.
REQ-009 The block SHALL have ports max_value_1, max_value_2 and max_value_3, output, CONV_BIT each: registered pooled and ReLU'd results.
REQ-010 The block SHALL have port valid_out_relu, output, 1 bit: max_value_* are valid this cycle.

Function
REQ-011 The block SHALL accept a pixel only in cycles where valid_in=1; all counters and storage SHALL hold when valid_in=0.
REQ-012 The block SHALL track column (0..IN_WIDTH-1) and row (0..IN_HEIGHT-1) counters; column SHALL wrap to 0 and increment row after IN_WIDTH-1; row SHALL wrap to 0 after IN_HEIGHT-1, so the next frame may start in the next accepted cycle.
REQ-013 The row phase SHALL be a two-state machine, ROW_EVEN and ROW_ODD, that toggles on every column wrap and resets to ROW_EVEN.
REQ-014 On an even column, the block SHALL latch the pixel into a per-channel hold register.
REQ-015 In ROW_EVEN on an odd column, the block SHALL write the signed max of the hold register and the current pixel into line buffer entry column/2 (IN_WIDTH/2 entries per channel).
REQ-016 In ROW_ODD on an odd column, the block SHALL compute the signed max of the hold register, the current pixel and line buffer entry column/2, then apply ReLU (negative results become 0).
REQ-017 The block SHALL register the REQ-016 result into max_value_* and assert valid_out_relu for exactly one cycle on the clock edge following acceptance of that pixel (latency 1 cycle).
REQ-018 The block SHALL produce exactly (IN_WIDTH/2)*(IN_HEIGHT/2) outputs per frame (16 at default), in raster order of the pooled map.
REQ-019 All comparisons SHALL be signed at CONV_BIT width; max_value_* SHALL be in the range 0..2^(CONV_BIT-1)-1.
REQ-020 When valid_out_relu=0, max_value_* SHALL hold their last value.
REQ-021 The three channels SHALL share counters and the state machine and SHALL be processed identically in the same cycle.
REQ-022 valid_in=1 in every cycle across a frame boundary SHALL NOT drop or duplicate outputs.

Reset
REQ-023 While rst=1, counters SHALL be 0, the state SHALL be ROW_EVEN, hold registers and line buffers SHALL be 0, max_value_* SHALL be 0, and valid_out_relu SHALL be 0, independent of clk.
REQ-024 A reset asserted mid-frame SHALL discard the partial frame; the first accepted pixel after release SHALL be treated as row 0, column 0.
REQ-025 The block SHALL accept a pixel on the first rising edge after rst deasserts.

Verification
REQ-026 rst=1 with valid_in toggling and random data -> all outputs 0, valid_out_relu never 1.
REQ-027 Back-to-back frame, conv_out_1 = pixel index 0..63 -> 16 pulses; first value 9, one cycle after pixel 9 accepted; last value 63; sequence 9,11,13,15,25,...,63.
REQ-028 conv_out_2 = 0xFFB (-5) for a whole frame -> 16 pulses, all max_value_2=0.
REQ-029 One window {0x800, 0xFFF, 0x003, 0x002} -> output 3 (0xFFF treated as -1, not 4095); window {0x800, 0xFFF, 0xFFE, 0x801} -> output 0.
REQ-030 The REQ-027 frame with random valid_in gaps -> identical 16 values, each exactly one cycle after its completing pixel.
REQ-031 rst pulsed after 20 accepted pixels, then a full ramp frame -> exactly 16 outputs matching REQ-027; no output from the aborted frame.
